mem_repair_array: RTL and testbench
===================================

Name: mem_repair_array

Overview:
- Parametrised successor to the plain synchronous memory.
- Main word array plus NUM_SPARES spare words and a repair table that remaps failing addresses to spares.
- Programmable read latency; repair handshake driven by the MBISR controller.
- Sits between the MBIST/MBISR engine and the functional memory port.

Parameters:
ADDR_WIDTH, 8, address width
DATA_WIDTH, 8, word width
MEM_SIZE, 256, main-array words (≤ 2**ADDR_WIDTH)
NUM_SPARES, 4, spare words / repair-table entries (1..16)
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
CW, $clog2(NUM_SPARES+1), local width of repair_count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mem_en  in  1  access request
mem_we  in  1  1=write, 0=read
mem_addr  in  ADDR_WIDTH  access address
mem_wdata  in  DATA_WIDTH  write data
mem_rdata  out  DATA_WIDTH  read data
mem_rvalid  out  1  one-cycle pulse, mem_rdata valid
mem_ready  out  1  1 = access accepted this cycle
repair_req  in  1  request to map repair_addr to next free spare
repair_addr  in  ADDR_WIDTH  failing address
repair_ack  out  1  one-cycle completion pulse
repair_status  out  2  00 OK, 01 DUP, 10 FULL, 11 RANGE; valid with ack
repair_count  out  CW  spares allocated
repair_full  out  1  repair_count == NUM_SPARES

Behaviour:
- Reset (rst=1 at edge):
  - mem_rdata=0, mem_rvalid=0, repair_ack=0, repair_status=00, repair_count=0.
  - All table entries invalid; FSM to IDLE; read pipeline flushed.
  - Main and spare contents are not reset; they are zero at simulation start.
  - Reset mid-repair aborts with no ack.
- Access acceptance:
  - An access is accepted when mem_en && mem_ready.
  - mem_ready = (state==IDLE).
  - Accesses presented while not ready are dropped; the master must hold the request.
- Remap:
  - The accepted address is compared with all valid entries.
  - A match on entry i targets spare[i]; otherwise it targets main[addr].
  - Entries are unique, so at most one match.
- Write:
  - Targeted word is updated at the accepting edge.
  - addr ≥ MEM_SIZE with no table match: write ignored.
- Read:
  - RD_LATENCY=1: mem_rdata and mem_rvalid are registered at the edge after acceptance.
  - RD_LATENCY=2: one extra register stage.
  - Out-of-range read returns 0 with rvalid.
  - mem_rdata holds its value between reads.
  - Reads in flight complete even if a repair starts.
- Read-during-write: not applicable; a single port and one op per cycle.
- Repair FSM:
  - IDLE: repair_req latches repair_addr → LOOKUP.
  - LOOKUP: status priority is RANGE (addr ≥ MEM_SIZE) > DUP (already mapped) > FULL. Any of these → DONE; otherwise → COPY.
  - COPY: spare[repair_count] ← main[addr] (faulted read path if enabled); entry[repair_count] ← {valid, addr}; repair_count++ → DONE, status OK.
  - DONE: repair_ack=1 for one cycle → IDLE.
- Repair latency:
  - repair_req sampled at edge 0; ack high after edge 2 for RANGE/DUP/FULL, after edge 3 for OK.
  - repair_req is ignored outside IDLE.
- Simultaneous mem_en and repair_req in IDLE:
  - Access accepted first, using the pre-repair table.
  - mem_ready drops the next cycle.
- repair_full asserts the cycle after the last allocation; later requests return FULL (or DUP/RANGE by priority).

Optional Feature:
MEM_FAULT_INJECT_EN
- Defined: adds inputs fault_en(1), fault_addr(ADDR_WIDTH), fault_bit($clog2(DATA_WIDTH)), fault_val(1).
- While fault_en=1, any read of main[fault_addr], including the COPY read, returns stored data with bit fault_bit forced to fault_val (stuck-at).
- Spares are unaffected, so a repaired address reads correctly after a rewrite.
- Undefined: the ports are absent and reads are unmodified.

Decomposition:
- Package mem_repair_pkg holds:
  - repair_status encodings: ST_OK, ST_DUP, ST_FULL, ST_RANGE.
  - FSM state enum: IDLE, LOOKUP, COPY, DONE.
- Sub-module repair_cam:
  - Holds the NUM_SPARES valid+addr entries and the allocate port.
  - Outputs hit, hit_idx and a dup check for the latched repair address.

Test Plan:
- Write 0xA5 to addr 0x10, read with RD_LATENCY=1 → rvalid one cycle after accept, rdata=0xA5; RD_LATENCY=2 → two cycles.
- Repair 0x10 → status OK at cycle 3, count=1. Read 0x10 → 0xA5 (copied). Write 0x3C, read → 0x3C. main[0x10] still 0xA5 (hierarchical peek).
- Repair 0x10 again → DUP at cycle 2, count unchanged. Repair addr MEM_SIZE (param 200, addr 200) → RANGE. Out-of-range write is ignored and the read returns 0.
- Allocate NUM_SPARES=4 distinct addresses → repair_full=1. Fifth new address → FULL. mem_ready low exactly during non-IDLE cycles.
- mem_en read and repair_req on the same cycle → read served; mem_ready low next cycle. Assert rst during COPY → no ack, count=0, all addresses read main again.
- (MEM_FAULT_INJECT_EN) fault addr 0x20, bit 0 stuck-0; write 0xFF → reads 0xFE. Repair 0x20, rewrite 0xFF → reads 0xFF.

Source files
------------

// File: rtl/mem_repair_array_pkg.sv
// Shared types for the repairable memory array.
//   repair_status_e : status reported alongside repair_ack
//   repair_state_e  : repair FSM states
//   idx_width()     : index width helper that never returns zero
package mem_repair_pkg;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_DUP   = 2'b01,
        ST_FULL  = 2'b10,
        ST_RANGE = 2'b11
    } repair_status_e;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        COPY,
        DONE
    } repair_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_repair_array_if.sv
// Bus between the MBIST/MBISR engine (master) and the repairable memory (slave).
//   mem_*         : functional single-port access, read data returned with rvalid
//   repair_*      : repair request/ack handshake plus allocation status
//   fault_*       : stuck-at fault injection, present only with MEM_FAULT_INJECT_EN
interface mem_repair_array_if
    import mem_repair_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SPARES = 4
);
    localparam int CW  = $clog2(NUM_SPARES + 1);
    localparam int FBW = idx_width(DATA_WIDTH);

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;
    logic                  mem_ready;
    logic                  repair_req;
    logic [ADDR_WIDTH-1:0] repair_addr;
    logic                  repair_ack;
    logic [1:0]            repair_status;
    logic [CW-1:0]         repair_count;
    logic                  repair_full;
`ifdef MEM_FAULT_INJECT_EN
    logic                  fault_en;
    logic [ADDR_WIDTH-1:0] fault_addr;
    logic [FBW-1:0]        fault_bit;
    logic                  fault_val;
`endif

    modport master (
`ifdef MEM_FAULT_INJECT_EN
        output fault_en, fault_addr, fault_bit, fault_val,
`endif
        output mem_en, mem_we, mem_addr, mem_wdata, repair_req, repair_addr,
        input  mem_rdata, mem_rvalid, mem_ready, repair_ack, repair_status, repair_count,
        input  repair_full
    );

    modport slave (
`ifdef MEM_FAULT_INJECT_EN
        input  fault_en, fault_addr, fault_bit, fault_val,
`endif
        input  mem_en, mem_we, mem_addr, mem_wdata, repair_req, repair_addr,
        output mem_rdata, mem_rvalid, mem_ready, repair_ack, repair_status, repair_count,
        output repair_full
    );

endinterface

// File: rtl/mem_repair_array_repair_cam.sv
// Repair table: NUM_SPARES {valid, addr} entries, entry i owns spare word i.
//   clk, rst         : clock, synchronous active-high reset (invalidates all entries)
//   i_lookup_addr    : functional access address -> o_hit / o_hit_idx
//   i_dup_addr       : latched repair address    -> o_dup
//   i_alloc          : write entry i_alloc_idx with {1, i_alloc_addr}
module repair_cam #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_SPARES = 4,
    parameter int SW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_lookup_addr,
    output logic                  o_hit,
    output logic [SW-1:0]         o_hit_idx,
    input  logic [ADDR_WIDTH-1:0] i_dup_addr,
    output logic                  o_dup,
    input  logic                  i_alloc,
    input  logic [SW-1:0]         i_alloc_idx,
    input  logic [ADDR_WIDTH-1:0] i_alloc_addr
);
    logic [NUM_SPARES-1:0] r_valid;
    logic [ADDR_WIDTH-1:0] r_addr [NUM_SPARES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_alloc) begin
            r_valid[i_alloc_idx] <= 1'b1;
        end
    end

    // Address fields are qualified by r_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (i_alloc && !rst) begin
            r_addr[i_alloc_idx] <= i_alloc_addr;
        end
    end

    // Entries are unique, so at most one lookup hit.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        o_dup     = 1'b0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (r_valid[i] && (r_addr[i] == i_lookup_addr)) begin
                o_hit     = 1'b1;
                o_hit_idx = SW'(i);
            end
            if (r_valid[i] && (r_addr[i] == i_dup_addr)) begin
                o_dup = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_repair_array.sv
// Repairable single-port memory: main array, NUM_SPARES spare words and a repair table that
// redirects failing addresses to spares. Reads return after RD_LATENCY (1 or 2) cycles.
//   clk, rst : clock, synchronous active-high reset (contents of main/spares are kept)
//   bus      : mem_repair_array_if.slave (functional access + repair handshake)
// Optional: MEM_FAULT_INJECT_EN adds stuck-at fault injection on main-array reads.
module mem_repair_array
    import mem_repair_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 256,
    parameter int NUM_SPARES = 4,
    parameter int RD_LATENCY = 1
) (
    input logic               clk,
    input logic               rst,
    mem_repair_array_if.slave bus
);
    localparam int CW = $clog2(NUM_SPARES + 1);
    localparam int SW = idx_width(NUM_SPARES);
    localparam int MW = idx_width(MEM_SIZE);

    logic [DATA_WIDTH-1:0] r_main  [MEM_SIZE];
    logic [DATA_WIDTH-1:0] r_spare [NUM_SPARES];

    repair_state_e         r_state;
    repair_status_e        r_status;
    logic                  r_ack;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_rep_addr;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_rep_in_range;
    logic                  w_hit;
    logic [SW-1:0]         w_hit_idx;
    logic                  w_dup;
    logic                  w_alloc;
    logic [DATA_WIDTH-1:0] w_main_rd;
    logic [DATA_WIDTH-1:0] w_copy_rd;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_accept       = bus.mem_en && (r_state == IDLE) && !rst;
    assign w_in_range     = 32'(bus.mem_addr) < 32'(MEM_SIZE);
    assign w_rep_in_range = 32'(r_rep_addr) < 32'(MEM_SIZE);
    assign w_alloc        = (r_state == COPY) && !rst;

    repair_cam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SPARES (NUM_SPARES),
        .SW         (SW)
    ) u_cam (
        .clk           (clk),
        .rst           (rst),
        .i_lookup_addr (bus.mem_addr),
        .o_hit         (w_hit),
        .o_hit_idx     (w_hit_idx),
        .i_dup_addr    (r_rep_addr),
        .o_dup         (w_dup),
        .i_alloc       (w_alloc),
        .i_alloc_idx   (r_count[SW-1:0]),
        .i_alloc_addr  (r_rep_addr)
    );

    // Main-array read ports: functional access and the COPY source.
    always_comb begin
        w_main_rd = r_main[bus.mem_addr[MW-1:0]];
        w_copy_rd = r_main[r_rep_addr[MW-1:0]];
`ifdef MEM_FAULT_INJECT_EN
        if (bus.fault_en && (bus.mem_addr == bus.fault_addr)) begin
            w_main_rd[bus.fault_bit] = bus.fault_val;
        end
        if (bus.fault_en && (r_rep_addr == bus.fault_addr)) begin
            w_copy_rd[bus.fault_bit] = bus.fault_val;
        end
`endif
    end

    always_comb begin
        if (w_hit) begin
            w_rd_data = r_spare[w_hit_idx];
        end else if (w_in_range) begin
            w_rd_data = w_main_rd;
        end else begin
            w_rd_data = '0;
        end
    end

    // Storage: unmapped out-of-range writes fall through with no effect.
    always_ff @(posedge clk) begin
        if (w_accept && bus.mem_we) begin
            if (w_hit) begin
                r_spare[w_hit_idx] <= bus.mem_wdata;
            end else if (w_in_range) begin
                r_main[bus.mem_addr[MW-1:0]] <= bus.mem_wdata;
            end
        end
        if (w_alloc) begin
            r_spare[r_count[SW-1:0]] <= w_copy_rd;
        end
    end

    // Read pipeline stage 1; rdata holds between reads.
    logic                  r_rv1;
    logic [DATA_WIDTH-1:0] r_rd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv1 <= 1'b0;
            r_rd1 <= '0;
        end else begin
            r_rv1 <= w_accept && !bus.mem_we;
            if (w_accept && !bus.mem_we) begin
                r_rd1 <= w_rd_data;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  r_rv2;
        logic [DATA_WIDTH-1:0] r_rd2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rv2 <= 1'b0;
                r_rd2 <= '0;
            end else begin
                r_rv2 <= r_rv1;
                if (r_rv1) begin
                    r_rd2 <= r_rd1;
                end
            end
        end

        assign bus.mem_rvalid = r_rv2;
        assign bus.mem_rdata  = r_rd2;
    end else begin : g_lat1
        assign bus.mem_rvalid = r_rv1;
        assign bus.mem_rdata  = r_rd1;
    end

    // Repair FSM. RANGE beats DUP beats FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_status   <= ST_OK;
            r_ack      <= 1'b0;
            r_count    <= '0;
            r_rep_addr <= '0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.repair_req) begin
                        r_rep_addr <= bus.repair_addr;
                        r_state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!w_rep_in_range) begin
                        r_status <= ST_RANGE;
                        r_state  <= DONE;
                    end else if (w_dup) begin
                        r_status <= ST_DUP;
                        r_state  <= DONE;
                    end else if (r_count == CW'(NUM_SPARES)) begin
                        r_status <= ST_FULL;
                        r_state  <= DONE;
                    end else begin
                        r_state <= COPY;
                    end
                end
                COPY: begin
                    r_count  <= r_count + CW'(1);
                    r_status <= ST_OK;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_ack   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_ready     = (r_state == IDLE);
    assign bus.repair_ack    = r_ack;
    assign bus.repair_status = r_status;
    assign bus.repair_count  = r_count;
    assign bus.repair_full   = (r_count == CW'(NUM_SPARES));

endmodule

// File: tb/tb_mem_repair_array.sv
// Bench: two DUTs (RD_LATENCY 1 and 2) share one stimulus stream and are checked every cycle
// against a behavioural model (arrays + a queue for the repair table), plus directed checks.
module tb_mem_repair_array;
    import mem_repair_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MS = 200;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          en = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          rreq = 1'b0;
    logic [AW-1:0] raddr = '0;
`ifdef MEM_FAULT_INJECT_EN
    logic          f_en = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [2:0]    f_bit = '0;
    logic          f_val = 1'b0;
`endif

    mem_repair_array_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SPARES(NS)) if1 ();
    mem_repair_array_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SPARES(NS)) if2 ();

    assign if1.mem_en = en;      assign if2.mem_en = en;
    assign if1.mem_we = we;      assign if2.mem_we = we;
    assign if1.mem_addr = addr;  assign if2.mem_addr = addr;
    assign if1.mem_wdata = wdata; assign if2.mem_wdata = wdata;
    assign if1.repair_req = rreq; assign if2.repair_req = rreq;
    assign if1.repair_addr = raddr; assign if2.repair_addr = raddr;
`ifdef MEM_FAULT_INJECT_EN
    assign if1.fault_en = f_en;     assign if2.fault_en = f_en;
    assign if1.fault_addr = f_addr; assign if2.fault_addr = f_addr;
    assign if1.fault_bit = f_bit;   assign if2.fault_bit = f_bit;
    assign if1.fault_val = f_val;   assign if2.fault_val = f_val;
`endif

    mem_repair_array #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .NUM_SPARES(NS),
                       .RD_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    mem_repair_array #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .NUM_SPARES(NS),
                       .RD_LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_main [MS];
    logic [DW-1:0] m_spare [NS];
    int            tbl [$];        // tbl[i] = address mapped to spare i
    int            busy = 0;       // cycles the memory stays unavailable
    int            pend_addr = 0;
    int            pend_stat = 0;
    int            e_rv1 = 0, e_rd1 = 0, e_rv2 = 0, e_rd2 = 0, e_ack = 0, e_stat = 0;

    function automatic int find(input int a);
        for (int i = 0; i < tbl.size(); i++) if (tbl[i] == a) return i;
        return -1;
    endfunction

    function automatic int rd_main(input int a);
        logic [DW-1:0] v;
        v = m_main[a];
`ifdef MEM_FAULT_INJECT_EN
        if (f_en && (a == int'(f_addr))) v[f_bit] = f_val;
`endif
        return int'(v);
    endfunction

    always @(negedge clk) begin : model
        int h, n_rv1, n_rd1, n_ack;
        if (chk_on) begin
            chk("rvalid_l1", int'(if1.mem_rvalid), e_rv1);
            chk("rdata_l1", int'(if1.mem_rdata), e_rd1);
            chk("rvalid_l2", int'(if2.mem_rvalid), e_rv2);
            chk("rdata_l2", int'(if2.mem_rdata), e_rd2);
            chk("ready_l1", int'(if1.mem_ready), int'(busy == 0));
            chk("ready_l2", int'(if2.mem_ready), int'(busy == 0));
            chk("ack_l1", int'(if1.repair_ack), e_ack);
            chk("ack_l2", int'(if2.repair_ack), e_ack);
            chk("count", int'(if1.repair_count), tbl.size());
            chk("full", int'(if1.repair_full), int'(tbl.size() == NS));
            if (e_ack != 0) begin
                chk("status_l1", int'(if1.repair_status), e_stat);
                chk("status_l2", int'(if2.repair_status), e_stat);
            end
        end
        // Advance the model across the coming edge using the inputs now stable.
        if (rst) begin
            e_rv1 = 0; e_rd1 = 0; e_rv2 = 0; e_rd2 = 0; e_ack = 0; e_stat = 0;
            busy = 0;
            tbl.delete();
        end else begin
            n_rv1 = 0;
            n_rd1 = e_rd1;
            if (busy == 0 && en) begin
                h = find(int'(addr));
                if (we) begin
                    if (h >= 0) m_spare[h] = wdata;
                    else if (int'(addr) < MS) m_main[addr] = wdata;
                end else begin
                    n_rv1 = 1;
                    n_rd1 = (h >= 0) ? int'(m_spare[h]) : (int'(addr) < MS) ? rd_main(int'(addr)) : 0;
                end
            end
            e_rd2 = (e_rv1 != 0) ? e_rd1 : e_rd2;
            e_rv2 = e_rv1;
            e_rv1 = n_rv1;
            e_rd1 = n_rd1;
            n_ack = 0;
            if (busy > 0) begin
                if (busy == 2 && pend_stat == int'(ST_OK)) begin
                    m_spare[tbl.size()] = DW'(rd_main(pend_addr));
                    tbl.push_back(pend_addr);
                end
                busy--;
                if (busy == 0) begin
                    n_ack = 1;
                    e_stat = pend_stat;
                end
            end else if (rreq) begin
                pend_addr = int'(raddr);
                if (pend_addr >= MS) pend_stat = int'(ST_RANGE);
                else if (find(pend_addr) >= 0) pend_stat = int'(ST_DUP);
                else if (tbl.size() == NS) pend_stat = int'(ST_FULL);
                else pend_stat = int'(ST_OK);
                busy = (pend_stat == int'(ST_OK)) ? 3 : 2;
            end
            e_ack = n_ack;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!if1.mem_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_write(input int a, input int d);
        wait_ready();
        en = 1'b1; we = 1'b1; addr = AW'(a); wdata = DW'(d);
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic read_check(input string name, input int a, input int exp);
        wait_ready();
        en = 1'b1; we = 1'b0; addr = AW'(a);
        tick();
        en = 1'b0;
        chk({name, "_rv1"}, int'(if1.mem_rvalid), 1);
        chk({name, "_rd1"}, int'(if1.mem_rdata), exp);
        tick();
        chk({name, "_rv1_pulse"}, int'(if1.mem_rvalid), 0);
        chk({name, "_rv2"}, int'(if2.mem_rvalid), 1);
        chk({name, "_rd2"}, int'(if2.mem_rdata), exp);
    endtask

    task automatic do_repair(input string name, input int a, input int st, input int lat);
        int k = 0;
        wait_ready();
        rreq = 1'b1; raddr = AW'(a);
        tick();
        rreq = 1'b0;
        while (!if1.repair_ack && k < 10) begin
            tick();
            k++;
        end
        chk({name, "_lat"}, k, lat);
        chk({name, "_status"}, int'(if1.repair_status), st);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_rdata", int'(if1.mem_rdata), 0);
        chk("rst_rvalid", int'(if2.mem_rvalid), 0);
        chk("rst_ack", int'(if1.repair_ack), 0);
        chk("rst_status", int'(if1.repair_status), 0);
        chk("rst_count", int'(if1.repair_count), 0);
        chk("rst_ready", int'(if1.mem_ready), 1);
        rst = 1'b0;

        for (int a = 0; a < MS; a++) do_write(a, 0);

        do_write('h10, 'hA5);
        read_check("rd_a5", 'h10, 'hA5);

        do_repair("rep_ok", 'h10, int'(ST_OK), 3);
        chk("count_after_ok", int'(if1.repair_count), 1);
        read_check("rd_copied", 'h10, 'hA5);
        do_write('h10, 'h3C);
        read_check("rd_spare", 'h10, 'h3C);
        chk("main_peek", int'(u_dut1.r_main[16]), 'hA5);

        do_repair("rep_dup", 'h10, int'(ST_DUP), 2);
        chk("count_after_dup", int'(if1.repair_count), 1);
        do_repair("rep_range", MS, int'(ST_RANGE), 2);
        do_write(MS, 'h77);
        read_check("rd_oor", MS, 0);

        do_write('h30, 'h5A);
        do_repair("rep_20", 'h20, int'(ST_OK), 3);
        do_repair("rep_30", 'h30, int'(ST_OK), 3);
        do_repair("rep_40", 'h40, int'(ST_OK), 3);
        chk("full_set", int'(if1.repair_full), 1);
        chk("count_full", int'(if1.repair_count), 4);
        do_repair("rep_full", 'h50, int'(ST_FULL), 2);
        do_repair("rep_dup_when_full", 'h10, int'(ST_DUP), 2);
        do_repair("rep_range_when_full", MS + 1, int'(ST_RANGE), 2);

        // Read and repair request on the same edge.
        wait_ready();
        en = 1'b1; we = 1'b0; addr = 'h30; rreq = 1'b1; raddr = 'h60;
        tick();
        en = 1'b0; rreq = 1'b0;
        chk("simul_ready_low", int'(if1.mem_ready), 0);
        chk("simul_rv", int'(if1.mem_rvalid), 1);
        chk("simul_rd", int'(if1.mem_rdata), 'h5A);
        k = 0;
        while (!if1.repair_ack && k < 10) begin
            tick();
            k++;
        end
        chk("simul_lat", k, 2);
        chk("simul_status", int'(if1.repair_status), int'(ST_FULL));

        // Reset landing on the COPY edge aborts the repair.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready();
        rreq = 1'b1; raddr = 'h44;
        tick();
        rreq = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_count", int'(if1.repair_count), 0);
        chk("abort_ready", int'(if1.mem_ready), 1);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            if (if1.repair_ack) k++;
            tick();
        end
        chk("abort_no_ack", k, 0);
        read_check("rd_main_again", 'h10, 'hA5);

`ifdef MEM_FAULT_INJECT_EN
        f_en = 1'b1; f_addr = 'h20; f_bit = 3'd0; f_val = 1'b0;
        do_write('h20, 'hFF);
        read_check("rd_fault", 'h20, 'hFE);
        do_repair("rep_fault", 'h20, int'(ST_OK), 3);
        do_write('h20, 'hFF);
        read_check("rd_fault_fixed", 'h20, 'hFF);
        f_en = 1'b0;
`endif

        // Randomised traffic; every cycle is checked by the model process.
        for (int c = 0; c < 1500; c++) begin
            en    = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7))
                                                : AW'($urandom_range(0, 255));
            wdata = DW'($urandom_range(0, 255));
            rreq  = ($urandom_range(0, 7) == 0);
            raddr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(MS, 255))
                                                : AW'($urandom_range(0, 9));
            rst   = ($urandom_range(0, 149) == 0);
            tick();
        end
        en = 1'b0; rreq = 1'b0; rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
